// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: reset PC, fetch-engine
// state encoding and the buffered instruction record.
package if_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // IDLE: nothing outstanding; WAIT: one request in flight;
    // WAIT_SQ: the request in flight is wrong-path and its data will be dropped.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        WAIT_SQ = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo2.sv
// Two-entry instruction buffer. Entry 0 is always the head. Within one cycle
// the order is: pop, then tag-match clear (keep only pc == keep_pc), then push.
module if_fifo2
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         pop,
    input  logic         clr,
    input  logic [31:0]  keep_pc,
    input  logic         push,
    input  fetch_entry_t push_entry,
    output logic         head_valid,
    output fetch_entry_t head_entry,
    output logic [1:0]   count
);

    fetch_entry_t ent_q [2];
    fetch_entry_t ent_d [2];
    logic [1:0]   vld_q;
    logic [1:0]   vld_d;

    // Next buffer contents: pop, selective clear, compaction, then push.
    always_comb begin
        // NOTE: every always_comb output starts from a default so no path leaves
        // it unassigned (which would infer a latch); blocking '=' is used here
        // because later statements must see the earlier updates.
        ent_d = ent_q;
        vld_d = vld_q;

        if (pop && vld_d[0]) begin
            ent_d[0] = ent_d[1];
            vld_d[0] = vld_d[1];
            vld_d[1] = 1'b0;
        end

        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                if (ent_d[i].pc != keep_pc) begin
                    vld_d[i] = 1'b0;
                end
            end
        end

        if (!vld_d[0] && vld_d[1]) begin
            ent_d[0] = ent_d[1];
            vld_d    = 2'b01;
        end

        if (push) begin
            if (!vld_d[0]) begin
                ent_d[0] = push_entry;
                vld_d[0] = 1'b1;
            end else begin
                ent_d[1] = push_entry;
                vld_d[1] = 1'b1;
            end
        end
    end

    // Valid bits carry the buffer state and clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update
        // together from pre-edge values.
        if (reset) begin
            vld_q <= 2'b00;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload storage; meaningful only where the matching valid bit is set.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is deliberately not reset -- the valid bits
        // qualify it and the top zeroes the outputs while the buffer is empty.
        ent_q <= ent_d;
    end

    assign head_valid = vld_q[0];
    assign head_entry = ent_q[0];
    assign count      = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: generates the PC stream, keeps at most one request
// in flight to instruction memory, buffers returned words in if_fifo2 and
// applies decode redirects with MIPS delay-slot semantics.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc4,
    input  logic [31:0] redirect_target
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  tag_q, tag_d;
    logic         pending_q, pending_d;
    logic [31:0]  pend_pc4_q, pend_pc4_d;
    logic [31:0]  pend_target_q, pend_target_d;

    logic         head_valid;
    fetch_entry_t head_entry;
    logic [1:0]   fifo_count;
    logic         pop;
    logic         issue;
    logic         tag_miss;
    logic         push;
    fetch_entry_t push_entry;

    // A request may only go out with nothing in flight and buffer space for
    // its reply. Gated by reset so the port reads 0 while reset is held.
    assign imem_req  = !reset && (state_q == IDLE) && (fifo_count < DEPTH_C);
    assign imem_addr = {req_pc_q[31:2], 2'b00};

    assign pop   = head_valid && id_ready;
    assign issue = imem_req && imem_gnt;

    // The in-flight word is wrong-path if a redirect names a different delay slot.
    assign tag_miss   = redirect_valid && (tag_q != redirect_pc4);
    assign push       = imem_rvalid && (state_q == WAIT) && !tag_miss;
    assign push_entry = '{instr: imem_rdata, pc: tag_q};

    // Next fetch-engine state, request PC and delayed-redirect bookkeeping.
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        tag_d         = tag_q;
        pending_d     = pending_q;
        pend_pc4_d    = pend_pc4_q;
        pend_target_d = pend_target_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    tag_d   = req_pc_q;
                    state_d = (redirect_valid && (req_pc_q != redirect_pc4)) ? WAIT_SQ : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (tag_miss) begin
                    state_d = WAIT_SQ;
                end
            end
            WAIT_SQ: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Issuing the delay slot of a deferred redirect jumps straight to the target.
        if (issue) begin
            if (pending_q && (req_pc_q == pend_pc4_q)) begin
                req_pc_d  = pend_target_q;
                pending_d = 1'b0;
            end else begin
                req_pc_d = req_pc_q + 32'd4;
            end
        end

        // A redirect sees the post-grant PC; if the delay slot is still to be
        // fetched, defer the jump until it has been issued.
        if (redirect_valid) begin
            if (req_pc_d == redirect_pc4) begin
                pending_d     = 1'b1;
                pend_pc4_d    = redirect_pc4;
                pend_target_d = redirect_target;
            end else begin
                req_pc_d  = redirect_target;
                pending_d = 1'b0;
            end
        end
    end

    // Fetch-engine registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_pc_q      <= RESET_PC;
            tag_q         <= '0;
            pending_q     <= 1'b0;
            pend_pc4_q    <= '0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            tag_q         <= tag_d;
            pending_q     <= pending_d;
            pend_pc4_q    <= pend_pc4_d;
            pend_target_q <= pend_target_d;
        end
    end

    if_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .pop        (pop),
        .clr        (redirect_valid),
        .keep_pc    (redirect_pc4),
        .push       (push),
        .push_entry (push_entry),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    // Decode sees zeros whenever the buffer is empty.
    assign id_valid = head_valid;
    assign id_instr = head_valid ? head_entry.instr : '0;
    assign id_pc    = head_valid ? head_entry.pc : '0;
    assign id_pc4   = head_valid ? (head_entry.pc + 32'd4) : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        redirect_valid;
    logic [31:0] redirect_pc4;
    logic [31:0] redirect_target;

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc4          (id_pc4),
        .redirect_valid  (redirect_valid),
        .redirect_pc4    (redirect_pc4),
        .redirect_target (redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } smp_t;

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    // Memory stand-in: returns a word derived from the address after a latency.
    int          lat = 1;
    bit          rand_lat = 0;
    bit          rand_gnt = 0;
    int          gnt_block = 0;
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    // Reference model: instruction buffer as a queue of PCs plus fetch bookkeeping.
    logic [31:0] m_q[$];
    bit          m_out;
    bit          m_sq;
    logic [31:0] m_tag;
    logic [31:0] m_rpc;
    bit          m_pend;
    logic [31:0] m_pend_pc4;
    logic [31:0] m_pend_tgt;

    logic [31:0] got_q[$];
    logic [31:0] issued_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input logic [31:0] act_q[$],
                             input logic [31:0] exp_q[$]);
        foreach (exp_q[i]) begin
            if (i < act_q.size()) begin
                check($sformatf("%s[%0d]", name, i), act_q[i], exp_q[i]);
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s[%0d]: got nothing expected %h", name, i, exp_q[i]);
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out  = 0;
        m_sq   = 0;
        m_tag  = '0;
        m_rpc  = 32'h0000_3000;
        m_pend = 0;
        got_q.delete();
        issued_q.delete();
    endtask

    // Apply one clock edge's worth of events to the model, in the order the
    // fetch rules define: pop, response, issue, then redirect.
    task automatic model_step(input bit issue, input bit rvalid, input bit ready,
                              input bit redir, input logic [31:0] r_pc4,
                              input logic [31:0] r_tgt);
        logic [31:0] keep[$];
        if (m_q.size() != 0 && ready) void'(m_q.pop_front());
        if (rvalid && m_out) begin
            if (!m_sq) m_q.push_back(m_tag);
            m_out = 0;
            m_sq  = 0;
        end
        if (issue) begin
            m_out = 1;
            m_sq  = 0;
            m_tag = m_rpc;
            if (m_pend && m_rpc == m_pend_pc4) begin
                m_rpc  = m_pend_tgt;
                m_pend = 0;
            end else begin
                m_rpc = m_rpc + 32'd4;
            end
        end
        if (redir) begin
            foreach (m_q[i]) if (m_q[i] == r_pc4) keep.push_back(m_q[i]);
            m_q = keep;
            if (m_out && m_tag != r_pc4) m_sq = 1;
            if (m_rpc == r_pc4) begin
                m_pend     = 1;
                m_pend_pc4 = r_pc4;
                m_pend_tgt = r_tgt;
            end else begin
                m_rpc  = r_tgt;
                m_pend = 0;
            end
        end
    endtask

    task automatic zero_inputs();
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = '0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc4    = '0;
        redirect_target = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        zero_inputs();
        mem_busy  = 0;
        mem_cnt   = 0;
        gnt_block = 0;
        rand_lat  = 0;
        rand_gnt  = 0;
        lat       = 1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance at posedge.
    task automatic step(input bit ready, input bit redir, input logic [31:0] r_pc4,
                        input logic [31:0] r_tgt, output smp_t s);
        bit          m_req;
        bit          dut_issue;
        bit          rv;
        logic [31:0] iss_addr;
        @(negedge clk);
        imem_gnt        = (gnt_block == 0) && (rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1);
        rv              = mem_busy && (mem_cnt == 0);
        imem_rvalid     = rv;
        imem_rdata      = rv ? instr_of(mem_addr) : $urandom;
        id_ready        = ready;
        redirect_valid  = redir;
        redirect_pc4    = r_pc4;
        redirect_target = r_tgt;
        #1;
        s.req   = imem_req;
        s.addr  = imem_addr;
        s.valid = id_valid;
        s.pc    = id_pc;
        s.instr = id_instr;
        s.pc4   = id_pc4;
        m_req = !m_out && (m_q.size() < 2);
        check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) check("imem_addr", imem_addr, m_rpc & ~32'd3);
        check("id_valid", {31'd0, id_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check("id_pc", id_pc, m_q[0]);
            check("id_instr", id_instr, instr_of(m_q[0]));
            check("id_pc4", id_pc4, m_q[0] + 32'd4);
        end
        if (id_valid && id_ready) got_q.push_back(id_pc);
        dut_issue = imem_req && imem_gnt;
        iss_addr  = imem_addr;
        @(posedge clk);
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (dut_issue) begin
            issued_q.push_back(iss_addr);
            mem_busy = 1;
            mem_addr = iss_addr;
            mem_cnt  = (rand_lat ? int'($urandom_range(1, 4)) : lat) - 1;
        end
        model_step(m_req && imem_gnt, rv, ready, redir, r_pc4, r_tgt);
        if (gnt_block > 0) gnt_block--;
    endtask

    task automatic idle_steps(input int n, input bit ready);
        smp_t s;
        for (int i = 0; i < n; i++) step(ready, 1'b0, '0, '0, s);
    endtask

    // Common lead-in: 0x3000 popped, 0x3004 buffered, 0x3008 in flight,
    // then branch 0x3000 redirects to 0x3100.
    task automatic squash_prefix(input int late_lat);
        smp_t s;
        lat = 1;
        idle_steps(4, 1'b1);
        lat = late_lat;
        step(1'b0, 1'b0, '0, '0, s);
        step(1'b0, 1'b1, 32'h3004, 32'h3100, s);
    endtask

    vec_t vecs[7];

    initial begin
        smp_t        s;
        logic [31:0] exp_q[$];
        bit          blocked;
        bit          cand_valid;
        logic [31:0] cand_pc;
        logic [31:0] slot;

        reset = 1'b1;
        zero_inputs();
        model_reset();

        // Reset, latency 1, decode always ready.
        vecs[0] = '{1'b1, 32'h3000, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,    1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h3004, 1'b1, 32'h3000};
        vecs[3] = '{1'b0, 32'h0,    1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h3008, 1'b1, 32'h3004};
        vecs[5] = '{1'b0, 32'h0,    1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h300C, 1'b1, 32'h3008};

        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, '0, '0, s);
            check($sformatf("t1_req[%0d]", i), {31'd0, s.req}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) check($sformatf("t1_addr[%0d]", i), s.addr, vecs[i].exp_addr);
            check($sformatf("t1_valid[%0d]", i), {31'd0, s.valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("t1_pc[%0d]", i), s.pc, vecs[i].exp_pc);
                check($sformatf("t1_pc4[%0d]", i), s.pc4, vecs[i].exp_pc + 32'd4);
            end
        end

        // Decode stalls 5 cycles: buffer fills, requests stop, order kept.
        apply_reset();
        idle_steps(4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0, s);
        check("t2_req_stalled", {31'd0, s.req}, 32'd0);
        check("t2_head_pc", s.pc, 32'h3004);
        idle_steps(16, 1'b1);
        exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010};
        check_seq("t2_order", got_q, exp_q);

        // Redirect with the delay slot buffered and a wrong-path word in flight.
        apply_reset();
        squash_prefix(3);
        idle_steps(20, 1'b1);
        exp_q = '{32'h3000, 32'h3004, 32'h3100, 32'h3104};
        check_seq("t3_delivered", got_q, exp_q);
        exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h3100, 32'h3104};
        check_seq("t3_issued", issued_q, exp_q);

        // Redirect before the delay slot is issued: slot fetched, then target.
        apply_reset();
        lat = 4;
        idle_steps(5, 1'b1);
        gnt_block = 1;
        step(1'b1, 1'b1, 32'h3004, 32'h3100, s);
        idle_steps(18, 1'b1);
        exp_q = '{32'h3000, 32'h3004, 32'h3100};
        check_seq("t4_issued", issued_q, exp_q);
        check_seq("t4_delivered", got_q, exp_q);

        // Grant withheld 3 cycles: request and address hold.
        apply_reset();
        gnt_block = 3;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, '0, s);
            check($sformatf("t5_req[%0d]", i), {31'd0, s.req}, 32'd1);
            check($sformatf("t5_addr[%0d]", i), s.addr, 32'h3000);
        end
        idle_steps(4, 1'b1);
        exp_q = '{32'h3000};
        check_seq("t5_issued", issued_q, exp_q);

        // Reset while a squashed request is in flight; its late reply is ignored.
        apply_reset();
        squash_prefix(4);
        #2;
        reset = 1'b1;
        #1;
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_valid", {31'd0, id_valid}, 32'd0);
        check("t6_instr", id_instr, 32'd0);
        check("t6_pc", id_pc, 32'd0);
        check("t6_pc4", id_pc4, 32'd0);
        check("t6_addr", imem_addr, 32'h3000);
        zero_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        mem_busy  = 1;
        mem_cnt   = 0;
        gnt_block = 1;
        reset = 1'b0;
        step(1'b1, 1'b0, '0, '0, s);
        check("t6_stale_ignored", {31'd0, s.valid}, 32'd0);
        idle_steps(12, 1'b1);
        exp_q = '{32'h3000, 32'h3004};
        check_seq("t6_issued", issued_q, exp_q);
        check_seq("t6_delivered", got_q, exp_q);

        // Randomized traffic with legal redirects, checked against the model.
        apply_reset();
        rand_lat   = 1;
        rand_gnt   = 1;
        blocked    = 0;
        cand_valid = 0;
        cand_pc    = '0;
        slot       = '0;
        for (int c = 0; c < 3000; c++) begin
            bit          ready;
            bit          pop_now;
            bit          redir;
            logic [31:0] br_pc;
            logic [31:0] head;
            logic [31:0] tgt;
            ready   = ($urandom_range(0, 9) < 7);
            pop_now = (m_q.size() != 0) && ready;
            head    = pop_now ? m_q[0] : '0;
            br_pc   = pop_now ? head : cand_pc;
            redir   = !blocked && (pop_now || cand_valid) && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF8;
            else tgt = 32'h0000_3000 + 32'($urandom_range(0, 63)) * 32'd4;
            if (redir) begin
                blocked    = 1;
                slot       = br_pc + 32'd4;
                cand_valid = 0;
            end
            step(ready, redir, br_pc + 32'd4, tgt, s);
            if (pop_now && !redir) begin
                if (blocked) begin
                    if (head == slot) begin
                        blocked    = 0;
                        cand_valid = 0;
                    end
                end else begin
                    cand_valid = 1;
                    cand_pc    = head;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the PC stream.
- Issues word-fetch requests to a variable-latency instruction memory and buffers the returned instructions in a 2-entry FIFO.
- Presents {instr, pc, pc4} to the decode stage.
- Applies redirects from decode's next-PC logic with MIPS delay-slot semantics: the delay slot is always delivered, and wrong-path fetches are squashed.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  FIFO head valid toward decode.
- id_ready  in  1  decode accepts the head (the inverse of stall).
- id_instr  out  32  head instruction.
- id_pc  out  32  head PC.
- id_pc4  out  32  head PC+4.
- redirect_valid  in  1  decode resolved a taken jump/branch this cycle.
- redirect_pc4  in  32  pc4 of the branch, which is the delay-slot address.
- redirect_target  in  32  jump/branch target.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: req_pc=RESET_PC; FIFO empty; id_valid=0; imem_req=0; no outstanding request; pending=0; squash=0. id_instr, id_pc and id_pc4 are 0.
- Handshakes:
  - Pop occurs when id_valid && id_ready.
  - Issue occurs when imem_req && imem_gnt.
  - Response occurs when imem_rvalid.
- imem_req=1 when there is no outstanding request and (fifo_count + outstanding) < 2.
  - imem_addr=req_pc.
  - imem_req and imem_addr hold stable until gnt.
- Only one request may be outstanding. Response latency is at least 1 cycle after gnt.
- On issue:
  - The outstanding tag is set to req_pc.
  - If pending && req_pc==pend_pc4, then req_pc=pend_target and pending is cleared.
  - Otherwise req_pc=req_pc+4, wrapping mod 2^32.
- On response:
  - If squash is set, the data is discarded and squash is cleared.
  - Otherwise push {rdata, tag, tag+4}.
  - A push and a pop in the same cycle are both legal; the count is unchanged.
- FIFO: head drives the id_* outputs combinationally. Overflow is impossible by the issue rule.
- Redirect (evaluated after this cycle's pop):
  - FIFO entries with pc==redirect_pc4 are kept; all others are dropped.
  - An outstanding request whose tag!=redirect_pc4 sets squash. A response arriving the same cycle is judged by its tag directly.
  - If the delay slot is not yet issued (req_pc==redirect_pc4), latch pending, pend_pc4 and pend_target.
  - Otherwise req_pc=redirect_target.
  - A redirect in the same cycle as a grant uses the post-grant req_pc.
- A second redirect before the delay slot is delivered is a protocol violation. The latest redirect wins.
- Fetch-engine states:
  - IDLE: no outstanding request.
  - WAIT: request outstanding.
  - WAIT_SQ: outstanding request is squashed.
  - Transitions: IDLE→WAIT on issue; WAIT→WAIT_SQ on squash; WAIT or WAIT_SQ→IDLE on response.
- Reset mid-operation: all state clears immediately. An imem_rvalid with no outstanding request is ignored.
- imem_addr[1:0] is always 0. Misaligned targets are passed through unchecked.

Decomposition:
- Shared package holds RESET_PC and the state encoding (IDLE, WAIT, WAIT_SQ).
- Sub-module if_fifo2 implements the 2-entry {instr, pc} buffer with per-entry tag-match clear.
- The top module holds req_pc, the pending and squash logic, and the imem FSM.

Test Plan:
- Reset, imem latency 1, id_ready=1 -> first request addr 0x3000; id_pc sequence 0x3000, 0x3004, 0x3008 with id_pc4 = pc+4.
- id_ready=0 for 5 cycles -> FIFO fills to 2, imem_req deasserts, no data lost; on release, pc order is preserved.
- Branch at 0x3000 redirects (pc4=0x3004, target=0x3100) while 0x3004 is buffered and 0x3008 is outstanding -> 0x3008 is discarded; delivered sequence is 0x3004, 0x3100.
- Redirect arrives before 0x3004 is issued (latency 4) -> 0x3004 is fetched next, then 0x3100; no squash.
- imem_gnt held low 3 cycles -> imem_addr stable at 0x3000 throughout.
- Assert reset while WAIT_SQ -> outputs return to reset values immediately; a stale rvalid is ignored; the next request is 0x3000.
